// File: rtl/video_frame_checker.sv
// Purpose: measures per-frame active width/height, CRC-32 over active pixels, and geometry errors.
// Latency: results and the done pulse appear 2 cycles after the VSYNC active edge on i_vs.
// Backpressure: none; accepts one pixel per clock unconditionally.
module video_frame_checker #(
    parameter int EXP_HAC        = 800,
    parameter int EXP_VAC        = 600,
    parameter int VS_ACTIVE_HIGH = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_de,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [23:0] i_bgr,
    output logic        o_frame_done,
    output logic [11:0] o_width,
    output logic [11:0] o_height,
    output logic [31:0] o_crc,
    output logic        o_err_width,
    output logic        o_err_height,
    output logic [15:0] o_frame_cnt,
    output logic        o_locked
);

    localparam logic [11:0] HAC      = 12'(EXP_HAC);
    localparam logic [11:0] VAC      = 12'(EXP_VAC);
    localparam logic [11:0] CNT_MAX  = 12'hFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic {IDLE, RUN} state_t;

    // HSYNC is carried along the pipeline elsewhere; nothing here depends on it.
    logic unused_hs;
    assign unused_hs = i_hs;

    // VSYNC is normalised to active-high before registering so edge logic is polarity-free.
    logic vs_norm;
    assign vs_norm = (VS_ACTIVE_HIGH != 0) ? i_vs : ~i_vs;

    logic        de_q, de_prev, vs_q, vs_prev;
    logic [23:0] bgr_q;
    state_t      state_q, state_d;
    logic [11:0] line_cnt, height_cnt, last_width;
    logic        err_w_sticky;
    logic [31:0] crc_q;
    logic [1:0]  good_cnt;

    // MSB-first CRC-32 over one 24-bit pixel, bit 23 first.
    function automatic logic [31:0] crc24(input logic [31:0] c, input logic [23:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    logic        vs_edge, de_rise, de_fall, cut_line;
    logic        close_err_w, close_err_h, close_good;
    logic [11:0] close_height, close_width;
    logic [1:0]  good_next;
    logic [31:0] crc_pix;
    logic        restart, latch;

    // Edge detection and the "frame closing now" view, which folds in a line ending this cycle.
    always_comb begin
        vs_edge      = vs_q & ~vs_prev;
        de_rise      = de_q & ~de_prev;
        de_fall      = ~de_q & de_prev;
        cut_line     = vs_edge & de_q & de_prev;
        close_err_w  = err_w_sticky | (de_fall && (line_cnt != HAC)) | cut_line;
        close_height = (de_fall && (height_cnt != CNT_MAX)) ? height_cnt + 12'd1 : height_cnt;
        close_width  = de_fall ? line_cnt : last_width;
        close_err_h  = (close_height != VAC);
        close_good   = ~close_err_w & ~close_err_h;
        good_next    = !close_good ? 2'd0 : ((good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1);
        crc_pix      = crc24(crc_q, bgr_q);
    end

    // Input register stage plus one-cycle history for edge detection.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            de_q    <= 1'b0;
            de_prev <= 1'b0;
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
            bgr_q   <= '0;
        end else begin
            de_q    <= i_de;
            de_prev <= de_q;
            vs_q    <= vs_norm;
            vs_prev <= vs_q;
            bgr_q   <= i_bgr;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: the first VSYNC edge only arms the checker; later edges also latch results.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: if (vs_edge) begin
                state_d = RUN;
                restart = 1'b1;
            end
            RUN: if (vs_edge) begin
                latch   = 1'b1;
                restart = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-frame accumulators; a pixel arriving with the VSYNC edge opens the new frame.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            line_cnt     <= '0;
            height_cnt   <= '0;
            last_width   <= '0;
            err_w_sticky <= 1'b0;
            crc_q        <= CRC_INIT;
        end else if (restart) begin
            line_cnt     <= de_q ? 12'd1 : 12'd0;
            height_cnt   <= '0;
            last_width   <= '0;
            err_w_sticky <= 1'b0;
            crc_q        <= de_q ? crc24(CRC_INIT, bgr_q) : CRC_INIT;
        end else if (state_q == RUN) begin
            if (de_rise)                           line_cnt <= 12'd1;
            else if (de_q && line_cnt != CNT_MAX)  line_cnt <= line_cnt + 12'd1;
            if (de_fall) begin
                height_cnt   <= close_height;
                last_width   <= line_cnt;
                err_w_sticky <= close_err_w;
            end
            if (de_q) crc_q <= crc_pix;
        end
    end

    // Result latch, frame counter and lock tracking, all updated with the done pulse.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_frame_done <= 1'b0;
            o_width      <= '0;
            o_height     <= '0;
            o_crc        <= '0;
            o_err_width  <= 1'b0;
            o_err_height <= 1'b0;
            o_frame_cnt  <= '0;
            o_locked     <= 1'b0;
            good_cnt     <= '0;
        end else begin
            o_frame_done <= latch;
            if (latch) begin
                o_width      <= close_width;
                o_height     <= close_height;
                o_crc        <= ~crc_q;
                o_err_width  <= close_err_w;
                o_err_height <= close_err_h;
                o_frame_cnt  <= o_frame_cnt + 16'd1;
                good_cnt     <= good_next;
                o_locked     <= (good_next == 2'd2);
            end
        end
    end

endmodule

// File: tb/tb_video_frame_checker.sv
// Purpose: directed checks of geometry, CRC, error flags, lock and reset on a reduced frame size.
// Latency: expects results 2 cycles after each VSYNC edge presented on i_vs.
// Backpressure: none; inputs are driven every cycle.
module tb_video_frame_checker;

    localparam int HAC = 16;
    localparam int VAC = 12;

    logic        i_clk, i_rstn, i_de, i_hs, i_vs;
    logic [23:0] i_bgr;
    logic        o_frame_done, o_err_width, o_err_height, o_locked;
    logic [11:0] o_width, o_height;
    logic [31:0] o_crc;
    logic [15:0] o_frame_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] crc_m;
    logic [31:0] exp_crc;
    logic        vs_prev_m;

    video_frame_checker #(.EXP_HAC(HAC), .EXP_VAC(VAC), .VS_ACTIVE_HIGH(1)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs), .i_bgr(i_bgr),
        .o_frame_done(o_frame_done), .o_width(o_width), .o_height(o_height), .o_crc(o_crc),
        .o_err_width(o_err_width), .o_err_height(o_err_height), .o_frame_cnt(o_frame_cnt),
        .o_locked(o_locked)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Byte-serial reference CRC (MSB-first, poly 0x04C11DB7).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 7; k >= 0; k--) begin
            fb = r[31] ^ b[k];
            r  = r << 1;
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_pixel(input logic [31:0] c, input logic [23:0] p);
        logic [31:0] r;
        r = crc_byte(c, p[23:16]);
        r = crc_byte(r, p[15:8]);
        r = crc_byte(r, p[7:0]);
        return r;
    endfunction

    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        logic [7:0] xb, yb;
        xb = 8'(x);
        yb = 8'(y);
        return (mode != 0) ? {xb, yb, 8'hA5} : 24'h000000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One input cycle; the reference CRC follows the frame boundary rules of the stream.
    task automatic drive(input logic de, input logic vs, input logic [23:0] bgr);
        if (vs && !vs_prev_m) begin
            exp_crc = ~crc_m;
            crc_m   = 32'hFFFFFFFF;
        end
        if (de) crc_m = crc_pixel(crc_m, bgr);
        vs_prev_m = vs;
        i_de  = de;
        i_vs  = vs;
        i_hs  = ~de;
        i_bgr = bgr;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_results(input string tag, input int w, input int h, input logic ew,
                                 input logic eh, input int cnt, input logic lk);
        chk({tag, "_done"},   32'(o_frame_done), 32'd1);
        chk({tag, "_width"},  32'(o_width),      32'(w));
        chk({tag, "_height"}, 32'(o_height),     32'(h));
        chk({tag, "_err_w"},  32'(o_err_width),  32'(ew));
        chk({tag, "_err_h"},  32'(o_err_height), 32'(eh));
        chk({tag, "_crc"},    o_crc,             exp_crc);
        chk({tag, "_cnt"},    32'(o_frame_cnt),  32'(cnt));
        chk({tag, "_locked"}, 32'(o_locked),     32'(lk));
    endtask

    // Three-cycle VSYNC pulse; the done pulse must land exactly on the second cycle's output.
    task automatic vsync_latch(input string tag, input logic exp_done, input int w, input int h,
                               input logic ew, input logic eh, input int cnt, input logic lk);
        drive(1'b0, 1'b1, 24'h0);
        chk({tag, "_done_early"}, 32'(o_frame_done), 32'd0);
        drive(1'b0, 1'b1, 24'h0);
        if (exp_done) check_results(tag, w, h, ew, eh, cnt, lk);
        else          chk({tag, "_no_done"}, 32'(o_frame_done), 32'd0);
        drive(1'b0, 1'b0, 24'h0);
        chk({tag, "_done_late"}, 32'(o_frame_done), 32'd0);
    endtask

    task automatic body(input int mode, input int nlines, input int short_idx, input int short_len);
        int len;
        for (int b = 0; b < 4; b++) drive(1'b0, 1'b0, 24'h0);
        for (int y = 0; y < nlines; y++) begin
            len = (y == short_idx) ? short_len : HAC;
            for (int x = 0; x < len; x++) drive(1'b1, 1'b0, pix(mode, x, y));
            for (int b = 0; b < 8; b++) drive(1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"},   32'(o_frame_done), 32'd0);
        chk({tag, "_width"},  32'(o_width),      32'd0);
        chk({tag, "_height"}, 32'(o_height),     32'd0);
        chk({tag, "_crc"},    o_crc,             32'd0);
        chk({tag, "_err_w"},  32'(o_err_width),  32'd0);
        chk({tag, "_err_h"},  32'(o_err_height), 32'd0);
        chk({tag, "_cnt"},    32'(o_frame_cnt),  32'd0);
        chk({tag, "_locked"}, 32'(o_locked),     32'd0);
    endtask

    initial begin
        i_rstn = 1'b0; i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b0; i_bgr = '0;
        crc_m = 32'hFFFFFFFF; exp_crc = 32'h0; vs_prev_m = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge i_clk); #1;
        i_rstn = 1'b1;

        // Arm from IDLE, then a nominal constant-zero frame.
        vsync_latch("arm", 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        body(0, VAC, -1, 0);
        vsync_latch("nominal", 1'b1, HAC, VAC, 1'b0, 1'b0, 1, 1'b0);

        // Three identical counter-pattern frames: lock rises with the second clean latch.
        body(1, VAC, -1, 0);
        vsync_latch("lock_a", 1'b1, HAC, VAC, 1'b0, 1'b0, 2, 1'b1);
        body(1, VAC, -1, 0);
        vsync_latch("lock_b", 1'b1, HAC, VAC, 1'b0, 1'b0, 3, 1'b1);
        body(1, VAC, -1, 0);
        vsync_latch("lock_c", 1'b1, HAC, VAC, 1'b0, 1'b0, 4, 1'b1);

        // Line 10 one pixel short, then a clean frame that must not re-lock yet.
        body(1, VAC, 9, HAC - 1);
        vsync_latch("short", 1'b1, HAC, VAC, 1'b1, 1'b0, 5, 1'b0);
        body(1, VAC, -1, 0);
        vsync_latch("clean", 1'b1, HAC, VAC, 1'b0, 1'b0, 6, 1'b0);

        // Cut frame: VSYNC edge arrives on pixel 7 of line 6 while DE is high.
        body(1, 5, -1, 0);
        for (int x = 0; x < 7; x++) drive(1'b1, 1'b0, pix(1, x, 5));
        drive(1'b1, 1'b1, pix(1, 7, 5));
        chk("cut_done_early", 32'(o_frame_done), 32'd0);
        drive(1'b1, 1'b0, pix(1, 8, 5));
        check_results("cut", HAC, 5, 1'b1, 1'b1, 7, 1'b0);
        for (int x = 9; x < HAC; x++) begin
            drive(1'b1, 1'b0, pix(1, x, 5));
            if (x == 9) chk("cut_done_late", 32'(o_frame_done), 32'd0);
        end
        for (int b = 0; b < 8; b++) drive(1'b0, 1'b0, 24'h0);

        // Edges 2 cycles apart: closes the 9-pixel remnant frame, then two empty frames.
        drive(1'b0, 1'b1, 24'h0);
        drive(1'b0, 1'b0, 24'h0);
        check_results("remnant", 9, 1, 1'b1, 1'b1, 8, 1'b0);
        drive(1'b0, 1'b1, 24'h0);
        chk("empty1_gap", 32'(o_frame_done), 32'd0);
        drive(1'b0, 1'b0, 24'h0);
        chk("empty1_done",   32'(o_frame_done), 32'd1);
        chk("empty1_height", 32'(o_height),     32'd0);
        chk("empty1_width",  32'(o_width),      32'd0);
        chk("empty1_crc",    o_crc,             32'h00000000);
        chk("empty1_cnt",    32'(o_frame_cnt),  32'd9);
        drive(1'b0, 1'b1, 24'h0);
        chk("empty2_gap", 32'(o_frame_done), 32'd0);
        drive(1'b0, 1'b0, 24'h0);
        chk("empty2_done",   32'(o_frame_done), 32'd1);
        chk("empty2_height", 32'(o_height),     32'd0);
        chk("empty2_width",  32'(o_width),      32'd0);
        chk("empty2_crc",    o_crc,             32'h00000000);
        chk("empty2_err_h",  32'(o_err_height), 32'd1);
        chk("empty2_cnt",    32'(o_frame_cnt),  32'd10);
        drive(1'b0, 1'b0, 24'h0);
        chk("empty2_late", 32'(o_frame_done), 32'd0);

        // A clean frame so every output is non-zero before the reset.
        body(1, VAC, -1, 0);
        vsync_latch("pre_rst", 1'b1, HAC, VAC, 1'b0, 1'b0, 11, 1'b0);

        // Asynchronous reset in the middle of a line, away from any clock edge.
        body(1, 3, -1, 0);
        for (int x = 0; x < 5; x++) drive(1'b1, 1'b0, pix(1, x, 3));
        #2;
        i_rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        vs_prev_m = 1'b0;
        @(posedge i_clk); #3;
        i_rstn = 1'b1;
        for (int x = 5; x < HAC; x++) drive(1'b1, 1'b0, pix(1, x, 3));
        for (int b = 0; b < 8; b++) drive(1'b0, 1'b0, 24'h0);
        vsync_latch("rearm", 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        body(1, VAC, -1, 0);
        vsync_latch("post_rst", 1'b1, HAC, VAC, 1'b0, 1'b0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
